thermometer_rx: RTL
===================

# thermometer_rx

- Serial receiver for the 8-bit thermometer-coded pattern stream produced by the counter/decoder/memory/mux transmitter chain.
- Deserializes one bit per clock, LSB first, into 8-bit frames and checks each frame for a legal thermometer code (2^(k+1)-1).
- Recovers the 3-bit selector k and flags illegal frames.
- Sits at the far end of the serial link, driving downstream control logic with CODE/VALID/ERR.

## Interface
- CONTINUOUS, default 1: 1 = frames back-to-back after one START; 0 = return to IDLE after each frame.
- CLK  input  1  rising-edge clock; one serial bit per cycle.
- CLEAR_N  input  1  reset, asynchronous, active-low.
- DIN  input  1  serial data bit, sampled on each rising CLK.
- START  input  1  marks the current DIN sample as bit 0 of a new frame.
- DATA  output  8  last completed frame, bit i = i-th received bit.
- CODE  output  3  decoded selector k of the last accepted legal frame.
- VALID  output  1  one-cycle pulse per completed frame.
- ERR  output  1  one-cycle pulse, coincident with VALID, when the frame is not a legal thermometer code.
- BUSY  output  1  high while in RECV.

## Operation
- States: IDLE and RECV, with a 3-bit bit counter cnt and a 7-bit shift/hold register.
- Reset: state IDLE, cnt=0, register=0, DATA=8'h00, CODE=3'b000, VALID=0, ERR=0, BUSY=0.
- IDLE:
  - START=0: remain in IDLE and ignore DIN.
  - START=1: store DIN as bit 0, cnt becomes 1, next state RECV.
- RECV:
  - Each cycle, store DIN at position cnt and increment cnt.
  - When cnt=7, the frame completes on that edge: DATA is loaded with {DIN, bits[6:0]} and VALID is set.
- After frame completion:
  - CONTINUOUS=1: cnt wraps to 0 and the state stays RECV; the next DIN is bit 0 of the next frame.
  - CONTINUOUS=0: the state returns to IDLE.
- Legality check on each completed frame:
  - Legal frames are exactly 8'h01, 03, 07, 0F, 1F, 3F, 7F and FF, giving CODE=0..7 (k = number of ones minus 1).
  - Any other value, including 8'h00, is illegal: ERR=1 with VALID, and CODE holds its previous value.
  - DATA is updated on every completed frame, legal or not.
- START has priority in all states. START in RECV with cnt≠0 discards the partial frame without a VALID pulse; that DIN becomes bit 0 and cnt becomes 1.
- START on the cnt=7 edge also discards: no VALID, DIN is taken as bit 0.
- START at cnt=0 in continuous mode is redundant and changes nothing.
- CLEAR_N low mid-frame: everything returns to reset values immediately, the partial frame is lost, and no VALID is generated.

## Timing
- Latency: DATA, CODE, VALID and ERR change on the same edge that samples bit 7; they are visible in the cycle after the last bit.
- VALID and ERR are high for exactly one cycle per completed frame.
- Continuous mode: VALID pulses every 8 cycles, so 8 cycles separate consecutive VALIDs.
- BUSY:
  - Rises on the edge after START is sampled in IDLE.
  - In CONTINUOUS=0, falls on the frame-completion edge.
- Reset deassertion is asynchronous to clear only; the first capture occurs at the first rising edge with CLEAR_N=1 and START=1.
- All outputs are registered; there is no combinational path from DIN or START to any output.

## Configuration
- THERM_RX_CONFIRM_EN defined:
  - CODE updates only when two consecutive completed legal frames carry the same k.
  - An illegal frame, a START abort, or a differing k clears the match history, so the first legal frame after that arms only.
  - VALID and ERR behave as without the macro.
- THERM_RX_CONFIRM_EN undefined: CODE updates on every legal frame; no history register exists.

## Test plan
- Reset, then START with serial 1,1,1,0,0,0,0,0 (8'h07) -> on the 8th edge DATA=8'h07, CODE=2, VALID=1 for one cycle, ERR=0.
- CONTINUOUS=1, frames 8'h01 then 8'hFF back-to-back after one START -> VALID at cycles 8 and 16; CODE=0 then 7.
- Frame 8'h05 after a legal 8'h3F -> DATA=8'h05, VALID=1, ERR=1, CODE stays 5.
- START reasserted at bit 4 of a frame, then 8 bits of 8'h0F -> no VALID for the aborted frame; VALID 8 cycles after the second START with CODE=3.
- CLEAR_N pulsed low at bit 5 -> all outputs 0 immediately; no VALID until a new START plus 8 bits.
- THERM_RX_CONFIRM_EN: frames 8'h1F, 8'h7F, 8'h7F -> CODE unchanged, unchanged, then 6; three VALIDs.

Source files
------------

// File: rtl/thermometer_rx.sv
// thermometer_rx: LSB-first serial receiver that frames 8 bits and decodes thermometer codes.
// Optional feature: define THERM_RX_CONFIRM_EN to move CODE only after two matching legal frames.
module thermometer_rx #(
   parameter bit CONTINUOUS = 1'b1
) (
   input  logic       CLK,
   input  logic       CLEAR_N,
   input  logic       DIN,
   input  logic       START,
   output logic [7:0] DATA,
   output logic [2:0] CODE,
   output logic       VALID,
   output logic       ERR,
   output logic       BUSY
);

   typedef enum logic {IDLE, RECV} state_t;

   state_t     state, state_next;
   logic [2:0] cnt, cnt_next;
   logic [6:0] bits, bits_next;
   logic [7:0] frame;
   logic [7:0] data_next;
   logic [2:0] code_next;
   logic       valid_next, err_next;
   logic       legal;
   logic [2:0] k;
   logic       done;

`ifdef THERM_RX_CONFIRM_EN
   logic       hist_ok, hist_ok_next;
   logic [2:0] hist_k, hist_k_next;
`endif

   always_ff @(posedge CLK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         state <= IDLE;
         cnt   <= 3'd0;
         bits  <= 7'd0;
         DATA  <= 8'h00;
         CODE  <= 3'b000;
         VALID <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         bits  <= bits_next;
         DATA  <= data_next;
         CODE  <= code_next;
         VALID <= valid_next;
         ERR   <= err_next;
      end
   end

`ifdef THERM_RX_CONFIRM_EN
   always_ff @(posedge CLK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         hist_ok <= 1'b0;
         hist_k  <= 3'd0;
      end else begin
         hist_ok <= hist_ok_next;
         hist_k  <= hist_k_next;
      end
   end
`endif

   // frame is the full 8-bit word as it would look with this cycle's DIN merged in
   always_comb begin
      frame      = {1'b0, bits};
      frame[cnt] = DIN;

      legal = 1'b1;
      k     = 3'd0;
      case (frame)
         8'h01:   k = 3'd0;
         8'h03:   k = 3'd1;
         8'h07:   k = 3'd2;
         8'h0F:   k = 3'd3;
         8'h1F:   k = 3'd4;
         8'h3F:   k = 3'd5;
         8'h7F:   k = 3'd6;
         8'hFF:   k = 3'd7;
         default: legal = 1'b0;
      endcase

      state_next = state;
      cnt_next   = cnt;
      bits_next  = bits;
      data_next  = DATA;
      code_next  = CODE;
      valid_next = 1'b0;
      err_next   = 1'b0;
      done       = 1'b0;

      if (START) begin
         bits_next  = {6'd0, DIN};
         cnt_next   = 3'd1;
         state_next = RECV;
      end else if (state == RECV) begin
         bits_next = frame[6:0];
         cnt_next  = cnt + 3'd1;
         if (cnt == 3'd7) begin
            done       = 1'b1;
            data_next  = frame;
            valid_next = 1'b1;
            err_next   = !legal;
            if (!CONTINUOUS) state_next = IDLE;
         end
      end

`ifdef THERM_RX_CONFIRM_EN
      // A START that cuts a partial frame, or any illegal frame, forgets the previous k
      hist_ok_next = hist_ok;
      hist_k_next  = hist_k;
      if (START && (state == RECV) && (cnt != 3'd0)) begin
         hist_ok_next = 1'b0;
      end else if (done) begin
         if (!legal) begin
            hist_ok_next = 1'b0;
         end else begin
            if (hist_ok && (hist_k == k)) code_next = k;
            hist_ok_next = 1'b1;
            hist_k_next  = k;
         end
      end
`else
      if (done && legal) code_next = k;
`endif
   end

   assign BUSY = (state == RECV);

endmodule
